// File: rtl/biquad8_pole_iir.sv
`default_nettype none
// ============================================================================
// Module   : biquad8_pole_iir
// Brief    : Two-state pole recursion closing an 8-sample block IIR, with
//            double-buffered Q4.14 feedback coefficients.
// Revision : 1.0
// ============================================================================
module biquad8_pole_iir #(
    parameter int NBITS   = 48,
    parameter int NFRAC   = 27,
    parameter     CLKTYPE = "NONE"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [17:0]      coeff_dat_i,
    input  logic                    coeff_wr_i,
    input  logic                    coeff_update_i,
    input  logic signed [NBITS-1:0] y0_fir_in,
    input  logic signed [NBITS-1:0] y1_fir_in,
    output logic signed [NBITS-1:0] y0_out,
    output logic signed [NBITS-1:0] y1_out
);

    localparam int c_PROD_W = NBITS + 18;
    localparam int c_SUM_W  = c_PROD_W + 1;
    localparam int c_CSHIFT = 14;

    // Coefficients sit outside the reset domain so a datapath reset keeps the loaded response.
    logic signed [17:0] r_sa = '0, r_sb = '0, r_sc = '0, r_sd = '0;
    logic signed [17:0] r_a  = '0, r_b  = '0, r_c  = '0, r_d  = '0;

    logic signed [NBITS-1:0] r_y0 = '0, r_y1 = '0;

    logic signed [c_PROD_W-1:0] w_pa, w_pb, w_pc, w_pd;
    logic signed [c_SUM_W-1:0]  w_acc0, w_acc1;
    logic signed [NBITS-1:0]    w_y0_next, w_y1_next;

    // Both operands sign-extended to the product width, so the low bits are the exact signed product.
    function automatic logic signed [c_PROD_W-1:0] f_mul(
        input logic signed [17:0]      c,
        input logic signed [NBITS-1:0] y
    );
        return {{NBITS{c[17]}}, c} * {{18{y[NBITS-1]}}, y};
    endfunction

    // Format and clock tag are informational; no datapath depends on them.
    if (NFRAC > 0 && NFRAC < NBITS) begin : g_fmt_ok
    end else begin : g_fmt_other
    end

    if (CLKTYPE == "NONE") begin : g_clk_untagged
    end else begin : g_clk_tagged
    end

    always_ff @(posedge clk) begin
        if (coeff_update_i) begin
            r_a <= r_sa;
            r_b <= r_sb;
            r_c <= r_sc;
            r_d <= r_sd;
        end
        if (coeff_wr_i) begin
            r_sa <= r_sb;
            r_sb <= r_sc;
            r_sc <= r_sd;
            r_sd <= coeff_dat_i;
        end
    end

    assign w_pa = f_mul(r_a, r_y0);
    assign w_pb = f_mul(r_b, r_y1);
    assign w_pc = f_mul(r_c, r_y0);
    assign w_pd = f_mul(r_d, r_y1);

    assign w_acc0 = c_SUM_W'(w_pa) + c_SUM_W'(w_pb);
    assign w_acc1 = c_SUM_W'(w_pc) + c_SUM_W'(w_pd);

    // Arithmetic shift floors; the add wraps modulo 2^NBITS by design.
    assign w_y0_next = y0_fir_in + NBITS'(w_acc0 >>> c_CSHIFT);
    assign w_y1_next = y1_fir_in + NBITS'(w_acc1 >>> c_CSHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y0 <= '0;
            r_y1 <= '0;
        end else begin
            r_y0 <= w_y0_next;
            r_y1 <= w_y1_next;
        end
    end

    assign y0_out = r_y0;
    assign y1_out = r_y1;

endmodule
`default_nettype wire

// File: tb/tb_biquad8_pole_iir.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_biquad8_pole_iir
// Brief    : Directed and random checks of biquad8_pole_iir against a
//            wide-arithmetic reference model through a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_biquad8_pole_iir;

    localparam int c_NB = 48;
    localparam int c_SW = c_NB + 19;

    typedef logic signed [c_NB-1:0] word_t;
    typedef logic signed [17:0]     coef_t;
    typedef struct packed {
        word_t y0;
        word_t y1;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    coef_t coeff_dat_i = '0;
    logic  coeff_wr_i = 1'b0;
    logic  coeff_update_i = 1'b0;
    word_t y0_fir_in = '0;
    word_t y1_fir_in = '0;
    word_t y0_out;
    word_t y1_out;

    int vectors = 0;
    int fails   = 0;
    exp_t sb[$];

    word_t m_y0 = '0, m_y1 = '0;
    coef_t m_sa = '0, m_sb = '0, m_sc = '0, m_sd = '0;
    coef_t m_a  = '0, m_b  = '0, m_c  = '0, m_d  = '0;

    biquad8_pole_iir #(
        .NBITS   (c_NB),
        .NFRAC   (27),
        .CLKTYPE ("NONE")
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coeff_dat_i    (coeff_dat_i),
        .coeff_wr_i     (coeff_wr_i),
        .coeff_update_i (coeff_update_i),
        .y0_fir_in      (y0_fir_in),
        .y1_fir_in      (y1_fir_in),
        .y0_out         (y0_out),
        .y1_out         (y1_out)
    );

    always #5 clk = ~clk;

    function automatic word_t model_next(input word_t fir, input coef_t ca, input coef_t cb,
                                         input word_t ya, input word_t yb);
        logic signed [c_SW-1:0] s;
        s = c_SW'(ca) * c_SW'(ya) + c_SW'(cb) * c_SW'(yb);
        return fir + c_NB'(s >>> 14);
    endfunction

    task automatic chk(input string tag, input word_t got, input word_t exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic wr, input coef_t d, input logic up,
                        input word_t f0, input word_t f1);
        exp_t e;
        rst = r;
        coeff_wr_i = wr;
        coeff_dat_i = d;
        coeff_update_i = up;
        y0_fir_in = f0;
        y1_fir_in = f1;
        if (r) begin
            e.y0 = '0;
            e.y1 = '0;
        end else begin
            e.y0 = model_next(f0, m_a, m_b, m_y0, m_y1);
            e.y1 = model_next(f1, m_c, m_d, m_y0, m_y1);
        end
        sb.push_back(e);
        if (up) begin
            m_a = m_sa; m_b = m_sb; m_c = m_sc; m_d = m_sd;
        end
        if (wr) begin
            m_sa = m_sb; m_sb = m_sc; m_sc = m_sd; m_sd = d;
        end
        m_y0 = e.y0;
        m_y1 = e.y1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_y0", y0_out, e.y0);
        chk("sb_y1", y1_out, e.y1);
        rst = 1'b0;
        coeff_wr_i = 1'b0;
        coeff_update_i = 1'b0;
        y0_fir_in = '0;
        y1_fir_in = '0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic write_coef(input coef_t v);
        tick(1'b0, 1'b1, v, 1'b0, '0, '0);
    endtask

    task automatic load(input coef_t a, input coef_t b, input coef_t c, input coef_t d);
        write_coef(a);
        write_coef(b);
        write_coef(c);
        write_coef(d);
        tick(1'b0, 1'b0, '0, 1'b1, '0, '0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, 1'b0, 48'h0000_1234_5678, 48'h0000_0000_0999);
    endtask

    initial begin
        word_t exp_v;

        #1;
        chk("por_y0", y0_out, '0);
        chk("por_y1", y1_out, '0);

        // All-zero power-up coefficients pass the FIR inputs straight through.
        tick(1'b0, 1'b0, '0, 1'b0, 48'h1000, 48'h2000);
        chk("pass_y0", y0_out, 48'h1000);
        chk("pass_y1", y1_out, 48'h2000);

        // A = +1.0 holds an impulse indefinitely.
        load(18'h04000, 18'h0, 18'h0, 18'h0);
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, 48'h100, '0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_y0", y0_out, 48'h100);
            chk("hold_y1", y1_out, '0);
            idle();
        end

        // Reset with live state zeroes outputs and keeps the coefficients.
        do_reset();
        chk("rst_y0", y0_out, '0);
        chk("rst_y1", y1_out, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 48'h100, '0);
        idle();
        chk("rst_keep_y0", y0_out, 48'h100);

        // Shadow writes alone leave the response untouched.
        write_coef(18'h0);
        write_coef(18'h0);
        write_coef(18'h04000);
        write_coef(18'h0);
        chk("shadow_y0", y0_out, 48'h100);
        tick(1'b0, 1'b0, '0, 1'b1, '0, '0);
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, 48'h100, '0);
        chk("c_t0_y0", y0_out, 48'h100);
        chk("c_t0_y1", y1_out, '0);
        idle();
        chk("c_t1_y0", y0_out, '0);
        chk("c_t1_y1", y1_out, 48'h100);
        idle();
        chk("c_t2_y1", y1_out, '0);

        // D = +0.5 halves y1 each block.
        load(18'h0, 18'h0, 18'h0, 18'h02000);
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, '0, 48'h1000);
        exp_v = 48'h1000;
        for (int i = 0; i < 4; i++) begin
            chk("half_y1", y1_out, exp_v);
            chk("half_y0", y0_out, '0);
            exp_v = exp_v >>> 1;
            idle();
        end

        // A = -1.0 alternates sign.
        load(18'h3C000, 18'h0, 18'h0, 18'h0);
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, 48'h100, '0);
        chk("neg_t0", y0_out, 48'h100);
        idle();
        chk("neg_t1", y0_out, -48'sh100);
        idle();
        chk("neg_t2", y0_out, 48'h100);

        // Accumulating the largest positive input wraps instead of saturating.
        load(18'h04000, 18'h0, 18'h0, 18'h0);
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, 48'h7FFF_FFFF_FFFF, '0);
        chk("wrap_t0", y0_out, 48'h7FFF_FFFF_FFFF);
        tick(1'b0, 1'b0, '0, 1'b0, 48'h7FFF_FFFF_FFFF, '0);
        chk("wrap_t1", y0_out, 48'hFFFF_FFFF_FFFE);
        tick(1'b0, 1'b0, '0, 1'b0, 48'h7FFF_FFFF_FFFF, '0);
        chk("wrap_t2", y0_out, 48'h7FFF_FFFF_FFFD);

        // Simultaneous write and update: active set takes the pre-shift shadow.
        do_reset();
        write_coef(18'h01800);
        write_coef(18'h3F000);
        write_coef(18'h00C00);
        tick(1'b0, 1'b1, 18'h02000, 1'b1, 48'h4000, 48'h3000);
        for (int i = 0; i < 12; i++)
            tick(1'b0, 1'b0, '0, 1'b0, word_t'({$urandom, $urandom}), word_t'({$urandom, $urandom}));
        tick(1'b0, 1'b0, '0, 1'b1, '0, '0);
        for (int i = 0; i < 12; i++)
            tick(1'b0, 1'b0, '0, 1'b0, word_t'($signed($urandom_range(0, 32'hFFFF)) - 32'sh8000),
                 word_t'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
